datablock_arbiter: RTL
======================

Name: datablock_arbiter

Overview:
Shares one 4-entry x 2-bit data block between two requesters using round-robin arbitration. Each requester uses a valid/ready request handshake. The block sequences each accepted access through a 3-state FSM: accept, access, respond. It sits between the two client ports and the datablock storage.

Parameters:
ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
DATA_W, 2, data width per entry

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  one clock; reset is asynchronous and active-low
req_valid  input  2  per-requester request valid; bit r = requester r
req_we  input  2  per-requester write enable; 1 = write, 0 = read
req_addr  input  2*ADDR_W  per-requester address; slice r = [r*ADDR_W +: ADDR_W]
req_wdata  input  2*DATA_W  per-requester write data; same slicing as req_addr
req_ready  output  2  per-requester accept; at most one bit high per cycle
rsp_valid  output  1  response valid
rsp_id  output  1  requester index the response belongs to
rsp_rdata  output  DATA_W  read data; for writes, the data just written
rsp_ready  input  1  response consumer ready

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0.
  - All DEPTH storage entries are cleared to 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Select a winner w among the set req_valid bits:
    - If only one bit is set, that requester wins.
    - If both are set, the winner is the requester != last_grant.
  - req_ready[w]=1 combinationally in IDLE; the other bit is 0.
  - Handshake is req_valid[w] & req_ready[w]. On handshake:
    - Latch we, addr, wdata and id=w.
    - Set last_grant=w and go to ACCESS.
  - With no valid request, stay in IDLE and keep req_ready=0.
- ACCESS (exactly 1 cycle):
  - Write: commit wdata to mem[addr] and set rsp_rdata=wdata.
  - Read: set rsp_rdata=mem[addr].
  - Set rsp_id=latched id, rsp_valid=1, and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_rdata stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid=0, go to IDLE.
  - req_ready=0 throughout ACCESS and RESP; only one access is outstanding at a time.
- Latency:
  - Request handshake in cycle N gives rsp_valid=1 from cycle N+2.
  - If rsp_ready is held high, the minimum issue interval is 3 cycles.
- Ordering: a read following a write to the same address returns the new data; no bypass is needed because accesses are serialized.
- Request stability: a requester must hold its addr/we/wdata stable while valid is high and ready is low. The arbiter samples these only on the handshake cycle.
- Address width: addresses are always in range; no wrap-around or error condition exists.
- Reset mid-operation:
  - The current transaction is aborted and no response is generated.
  - A write still in ACCESS is not committed.
- Simultaneous rsp handshake and new req_valid: no response-to-request bypass. The new request is seen in the following IDLE cycle.

Optional Feature:
- Macro DATABLOCK_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins a tie. last_grant is not implemented.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package datablock_pkg holds:
  - FSM state typedef: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Default ADDR_W and DATA_W constants.
  - NREQ=2.
- One sub-module, datablock_mem:
  - DEPTH x DATA_W storage with async-clear on rst_n.
  - Synchronous write port (we, waddr, wdata).
  - Combinational read port (raddr -> rdata).
- The FSM, arbitration and latches stay in datablock_arbiter.

Test Plan:
- Reset then read: after reset, req0 reads addr 2 with handshake at cycle N → rsp_valid=1 at N+2, rsp_id=0, rsp_rdata=2'b00; req_ready=2'b00 during N+1 and N+2.
- Write then read: req1 writes 2'b11 to addr 1, then req0 reads addr 1 → write response rsp_id=1, rsp_rdata=2'b11; read response rsp_id=0, rsp_rdata=2'b11; other addresses still 0.
- Tie arbitration: both requesters valid continuously with rsp_ready=1 → grant order 0,1,0,1 across 4 transactions; handshakes 3 cycles apart.
- Backpressure: rsp_ready=0 for 3 cycles in RESP → rsp_valid, rsp_id and rsp_rdata unchanged; req_ready stays 0; on rsp_ready=1 → IDLE in the next cycle.
- Reset mid-access: rst_n pulsed low during ACCESS of a write of 2'b10 to addr 3 → all outputs 0 immediately; a later read of addr 3 returns 2'b00; the first tie after reset goes to requester 0.
- Fixed priority: with DATABLOCK_ARB_FIXED_PRIO_EN defined and both valid continuously → requester 0 granted every transaction; requester 1 granted only once req_valid[0] drops.

Source files
------------

// File: rtl/datablock_pkg.sv
// Shared types and defaults for the two-requester datablock arbiter.
package datablock_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DATA_W = 2;
   localparam int NREQ       = 2;

endpackage

// File: rtl/datablock_mem.sv
// DEPTH x DATA_W register storage: async clear, synchronous write, combinational read.
module datablock_mem
   import datablock_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/datablock_arbiter.sv
// Round-robin arbiter sharing one datablock between two valid/ready requesters.
// Define DATABLOCK_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module datablock_arbiter
   import datablock_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rsp_valid,
   output logic                     rsp_id,
   output logic [DATA_W-1:0]        rsp_rdata,
   input  logic                     rsp_ready
);

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              id_q, id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              grant_w;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

`ifndef DATABLOCK_ARB_FIXED_PRIO_EN
   logic last_grant_q, last_grant_d;
`endif

   // A lone request wins outright; a tie goes by priority policy.
   always_comb begin
      grant_w = req_valid[1];
      if (req_valid == 2'b11) begin
`ifdef DATABLOCK_ARB_FIXED_PRIO_EN
         grant_w = 1'b0;
`else
         grant_w = ~last_grant_q;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = rsp_rdata_q;
      req_ready   = '0;
      mem_we      = 1'b0;
`ifndef DATABLOCK_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready[grant_w] = 1'b1;
               if (req_valid[grant_w] && req_ready[grant_w]) begin
                  we_d    = req_we[grant_w];
                  addr_d  = req_addr[int'(grant_w)*ADDR_W +: ADDR_W];
                  wdata_d = req_wdata[int'(grant_w)*DATA_W +: DATA_W];
                  id_d    = grant_w;
`ifndef DATABLOCK_ARB_FIXED_PRIO_EN
                  last_grant_d = grant_w;
`endif
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            mem_we      = we_q;
            rsp_rdata_d = we_q ? wdata_q : mem_rdata;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_rdata_q <= '0;
`ifndef DATABLOCK_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifndef DATABLOCK_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   datablock_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (addr_q),
      .wdata (wdata_q),
      .raddr (addr_q),
      .rdata (mem_rdata)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
